dmem_responder: RTL and testbench

- Memory-side responder for core load/store traffic: accepts one request over a valid/ready handshake, waits a programmable latency, then returns a response over a second valid/ready handshake.
- Owns a word-organised data RAM with RV32I byte-lane semantics: LB/LH/LW/LBU/LHU and SB/SH/SW, little-endian.
- Flags misaligned, out-of-range and illegal-funct3 accesses.
- Sits between a multi-cycle or pipelined core's memory stage and storage. It replaces the zero-latency combinational data memory path.

---
 rtl/dmem_responder_if.sv | 40 ++++
 rtl/dmem_responder.sv | 206 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bundle between a core memory stage and dmem_responder.
// master = core side, slave = responder side.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid,
        input  req_ready,
        output req_we,
        output req_addr,
        output req_wdata,
        output req_funct3,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_rdata,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  req_funct3,
        output rsp_valid,
        input  rsp_ready,
        output rsp_rdata,
        output rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Latency-programmable data memory responder with RV32I byte-lane
// load/store semantics and access error flagging.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input logic              clk,
    input logic              rst,
    dmem_responder_if.slave  bus
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          accept;
    logic          commit;

    logic          lat_we;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic [2:0]    lat_f3;

    logic          c_we;
    logic [31:0]   c_addr;
    logic [31:0]   c_wdata;
    logic [2:0]    c_f3;

    logic          oor;
    logic          mis_h;
    logic          mis_w;
    logic          ill;
    logic          err;

    logic [IW-1:0] idx;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   ld_data;
    logic [3:0]    be;
    logic [31:0]   wd;

    logic [31:0]   mem [DEPTH_WORDS];

    // State, countdown and request latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_f3    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                lat_we    <= bus.req_we;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
                lat_f3    <= bus.req_funct3;
            end
        end
    end

    // Next state, handshakes and the commit strobe.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        accept        = 1'b0;
        commit        = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    cnt_nxt = CW'(LATENCY - 1);
                    if (LATENCY > 1) begin
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = RESP;
                        commit    = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt == CW'(1)) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end
                cnt_nxt = cnt - 1'b1;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // With LATENCY=1 the commit edge is the accept edge, so the
    // request is taken straight from the bus in IDLE.
    always_comb begin
        c_we    = lat_we;
        c_addr  = lat_addr;
        c_wdata = lat_wdata;
        c_f3    = lat_f3;
        if (state == IDLE) begin
            c_we    = bus.req_we;
            c_addr  = bus.req_addr;
            c_wdata = bus.req_wdata;
            c_f3    = bus.req_funct3;
        end
    end

    // Access checks: range, alignment and funct3 legality.
    always_comb begin
        oor   = {1'b0, c_addr} >= LIMIT;
        mis_h = (c_f3[1:0] == 2'b01) && c_addr[0];
        mis_w = (c_f3 == 3'b010) && (c_addr[1:0] != 2'b00);
        ill   = 1'b0;
        if (c_we) begin
            ill = (c_f3 != 3'b000) && (c_f3 != 3'b001) &&
                  (c_f3 != 3'b010);
        end else begin
            ill = (c_f3 == 3'b011) || (c_f3 == 3'b110) ||
                  (c_f3 == 3'b111);
        end
        err = oor || mis_h || mis_w || ill;
    end

    // Load extraction from the addressed word.
    always_comb begin
        idx     = c_addr[IW+1:2];
        rd_word = mem[idx];
        rd_byte = rd_word[{c_addr[1:0], 3'b000} +: 8];
        rd_half = c_addr[1] ? rd_word[31:16] : rd_word[15:0];
        ld_data = '0;
        unique case (c_f3)
            3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  ld_data = {24'b0, rd_byte};
            3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  ld_data = {16'b0, rd_half};
            3'b010:  ld_data = rd_word;
            default: ld_data = '0;
        endcase
    end

    // Store lane enables and lane-replicated write data.
    always_comb begin
        be = 4'b0000;
        wd = c_wdata;
        unique case (c_f3[1:0])
            2'b00: begin
                be = 4'b0001 << c_addr[1:0];
                wd = {4{c_wdata[7:0]}};
            end
            2'b01: begin
                be = c_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{c_wdata[15:0]}};
            end
            2'b10: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Byte-enable RAM write; only clean stores at the commit edge.
    always_ff @(posedge clk) begin
        if (!rst && commit && c_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
    end

    // Response registers: loaded at commit, cleared on handoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else if (commit) begin
            bus.rsp_rdata <= (c_we || err) ? 32'h0 : ld_data;
            bus.rsp_err   <= err;
        end else if (state == RESP && bus.rsp_ready) begin
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY 2, 1 and 4.
// Outputs are sampled on the falling edge.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          sel = 0;

    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        rsp_ready = 1'b0;

    logic        o_req_ready;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;

    int nvec = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    dmem_responder_if b0 ();
    dmem_responder_if b1 ();
    dmem_responder_if b2 ();

    assign b0.req_valid  = req_valid && (sel == 0);
    assign b1.req_valid  = req_valid && (sel == 1);
    assign b2.req_valid  = req_valid && (sel == 2);
    assign b0.rsp_ready  = rsp_ready && (sel == 0);
    assign b1.rsp_ready  = rsp_ready && (sel == 1);
    assign b2.rsp_ready  = rsp_ready && (sel == 2);
    assign b0.req_we     = req_we;
    assign b1.req_we     = req_we;
    assign b2.req_we     = req_we;
    assign b0.req_addr   = req_addr;
    assign b1.req_addr   = req_addr;
    assign b2.req_addr   = req_addr;
    assign b0.req_wdata  = req_wdata;
    assign b1.req_wdata  = req_wdata;
    assign b2.req_wdata  = req_wdata;
    assign b0.req_funct3 = req_funct3;
    assign b1.req_funct3 = req_funct3;
    assign b2.req_funct3 = req_funct3;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (
        .clk (clk),
        .rst (rst),
        .bus (b2.slave)
    );

    always_comb begin
        o_req_ready = b0.req_ready;
        o_rsp_valid = b0.rsp_valid;
        o_rsp_rdata = b0.rsp_rdata;
        o_rsp_err   = b0.rsp_err;
        if (sel == 1) begin
            o_req_ready = b1.req_ready;
            o_rsp_valid = b1.rsp_valid;
            o_rsp_rdata = b1.rsp_rdata;
            o_rsp_err   = b1.rsp_err;
        end else if (sel == 2) begin
            o_req_ready = b2.req_ready;
            o_rsp_valid = b2.rsp_valid;
            o_rsp_rdata = b2.rsp_rdata;
            o_rsp_err   = b2.rsp_err;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full request/response; hold>0 stalls rsp_ready and pokes
    // a stray store at the busy responder.
    task automatic xact(input string tag, input logic we,
                        input logic [31:0] a, input logic [31:0] wdat,
                        input logic [2:0] f3, input int lat,
                        input int hold, input logic [31:0] exp_rd,
                        input logic exp_err);
        int k;
        @(negedge clk);
        chk({tag, ".rdy"}, 32'(o_req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = a;
        req_wdata  = wdat;
        req_funct3 = f3;
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h0;
        req_funct3 = 3'b111;
        k = 1;
        while (!o_rsp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, ".lat"}, 32'(k), 32'(lat));
        chk({tag, ".rd"}, o_rsp_rdata, exp_rd);
        chk({tag, ".err"}, 32'(o_rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                req_valid  = 1'b1;
                req_we     = 1'b1;
                req_addr   = 32'h10;
                req_wdata  = 32'h0;
                req_funct3 = 3'b010;
            end
            if (i == 2) req_valid = 1'b0;
            @(negedge clk);
            chk({tag, ".hv"}, 32'(o_rsp_valid), 32'd1);
            chk({tag, ".hrd"}, o_rsp_rdata, exp_rd);
            chk({tag, ".herr"}, 32'(o_rsp_err), 32'(exp_err));
            chk({tag, ".hrdy"}, 32'(o_req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, ".done_v"}, 32'(o_rsp_valid), 32'd0);
        chk({tag, ".done_r"}, 32'(o_req_ready), 32'd1);
    endtask

    // Streaming with req_valid and rsp_ready held high.
    task automatic bb(input int s, input int lat);
        int acc[$];
        sel = s;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h40;
        req_funct3 = 3'b010;
        rsp_ready  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (o_req_ready) acc.push_back(c);
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        rsp_ready = 1'b0;
        chk("bb.n", 32'(acc.size() >= 3), 32'd1);
        if (acc.size() >= 3) begin
            chk("bb.gap0", 32'(acc[1] - acc[0]), 32'(lat + 1));
            chk("bb.gap1", 32'(acc[2] - acc[1]), 32'(lat + 1));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            chk("rst.rdy", 32'(o_req_ready), 32'd1);
            chk("rst.v", 32'(o_rsp_valid), 32'd0);
            chk("rst.rd", o_rsp_rdata, 32'h0);
            chk("rst.err", 32'(o_rsp_err), 32'd0);
        end
        rst = 1'b0;
        sel = 0;

        xact("sw10", 1, 32'h10, 32'hDEADBEEF, 3'b010, 2, 0, 0, 0);
        xact("lw10", 0, 32'h10, 0, 3'b010, 2, 0, 32'hDEADBEEF, 0);
        xact("sb11", 1, 32'h11, 32'h7F, 3'b000, 2, 0, 0, 0);
        xact("lw10b", 0, 32'h10, 0, 3'b010, 2, 0, 32'hDEAD7FEF, 0);
        xact("lb13", 0, 32'h13, 0, 3'b000, 2, 0, 32'hFFFFFFDE, 0);
        xact("lbu13", 0, 32'h13, 0, 3'b100, 2, 0, 32'h000000DE, 0);
        xact("lh12", 0, 32'h12, 0, 3'b001, 2, 0, 32'hFFFFDEAD, 0);
        xact("lhu10", 0, 32'h10, 0, 3'b101, 2, 0, 32'h00007FEF, 0);

        xact("lw12", 0, 32'h12, 0, 3'b010, 2, 0, 0, 1);
        xact("sw20", 1, 32'h20, 32'hCAFEF00D, 3'b010, 2, 0, 0, 0);
        xact("sh21", 1, 32'h21, 32'hBEEF, 3'b001, 2, 0, 0, 1);
        xact("lw20", 0, 32'h20, 0, 3'b010, 2, 0, 32'hCAFEF00D, 0);
        xact("f3_011", 0, 32'h10, 0, 3'b011, 2, 0, 0, 1);
        xact("st_f3_100", 1, 32'h20, 32'h0, 3'b100, 2, 0, 0, 1);
        xact("oor", 0, 32'h1000, 0, 3'b010, 2, 0, 0, 1);
        xact("lw20b", 0, 32'h20, 0, 3'b010, 2, 0, 32'hCAFEF00D, 0);

        xact("bp", 0, 32'h10, 0, 3'b010, 2, 5, 32'hDEAD7FEF, 0);
        @(negedge clk);
        chk("bp.noq", 32'(o_rsp_valid), 32'd0);
        xact("bp.lw", 0, 32'h10, 0, 3'b010, 2, 0, 32'hDEAD7FEF, 0);

        sel = 1;
        xact("l1.sw", 1, 32'h40, 32'h11223344, 3'b010, 1, 0, 0, 0);
        xact("l1.lw", 0, 32'h40, 0, 3'b010, 1, 0, 32'h11223344, 0);
        sel = 2;
        xact("l4.sw", 1, 32'h40, 32'h55667788, 3'b010, 4, 0, 0, 0);
        xact("l4.lw", 0, 32'h40, 0, 3'b010, 4, 0, 32'h55667788, 0);

        bb(1, 1);
        bb(2, 4);
        bb(0, 2);

        sel = 2;
        xact("r.clr", 1, 32'h30, 32'h0, 3'b010, 4, 0, 0, 0);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h30;
        req_wdata  = 32'h12345678;
        req_funct3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("r.rdy", 32'(o_req_ready), 32'd1);
        chk("r.v", 32'(o_rsp_valid), 32'd0);
        chk("r.rd", o_rsp_rdata, 32'h0);
        chk("r.err", 32'(o_rsp_err), 32'd0);
        repeat (4) @(negedge clk);
        chk("r.idle", 32'(o_rsp_valid), 32'd0);
        xact("r.lw", 0, 32'h30, 0, 3'b010, 4, 0, 32'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
